// File: rtl/gfx256_wbm_read.sv
// Single-beat classic Wishbone read master shared by the z, blend and tex clients.
// Fixed priority z > blend > tex; one bus read per grant, one-cycle client ack.
module gfx256_wbm_read #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         z_request_i,
  input  logic [31:0]  z_addr_i,
  input  logic [31:0]  z_sel_i,
  output logic [255:0] z_data_o,
  output logic         z_ack_o,
  input  logic         blend_request_i,
  input  logic [31:0]  blend_addr_i,
  input  logic [31:0]  blend_sel_i,
  output logic [255:0] blend_data_o,
  output logic         blend_ack_o,
  input  logic         tex_request_i,
  input  logic [31:0]  tex_addr_i,
  input  logic [31:0]  tex_sel_i,
  output logic [255:0] tex_data_o,
  output logic         tex_ack_o,
  output logic         wbm_busy_o,
  output logic         err_o,
  output logic         cyc_o,
  output logic         stb_o,
  output logic         we_o,
  output logic [2:0]   cti_o,
  output logic [1:0]   bte_o,
  output logic [31:0]  adr_o,
  output logic [31:0]  sel_o,
  input  logic [255:0] dat_i,
  input  logic         ack_i,
  input  logic         err_i
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [2:0]          win_q, win_d;     // one-hot {tex, blend, z}
  logic [31:0]         adr_q, adr_d;
  logic [31:0]         sel_q, sel_d;
  logic                cyc_q, cyc_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [2:0]          ack_q, ack_d;
  logic [2:0][255:0]   data_q, data_d;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    data_d  = data_q;
    ack_d   = 3'b000;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (z_request_i || blend_request_i || tex_request_i) begin
          if (z_request_i) begin
            win_d = 3'b001;
            adr_d = z_addr_i & ~32'h1F;
            sel_d = z_sel_i;
          end else if (blend_request_i) begin
            win_d = 3'b010;
            adr_d = blend_addr_i & ~32'h1F;
            sel_d = blend_sel_i;
          end else begin
            win_d = 3'b100;
            adr_d = tex_addr_i & ~32'h1F;
            sel_d = tex_sel_i;
          end
          state_d = S_BUS;
          cyc_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      S_BUS: begin
        cnt_d = cnt_q + 8'd1;
        // ack_i takes precedence over err_i and timeout
        if (ack_i || err_i || (cnt_d == 8'(TIMEOUT))) begin
          for (int i = 0; i < 3; i++)
            if (win_q[i]) data_d[i] = ack_i ? dat_i : '0;
          err_d   = !ack_i;
          ack_d   = win_q;
          cyc_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      cyc_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  assign cyc_o        = cyc_q;
  assign stb_o        = cyc_q;
  assign we_o         = 1'b0;
  assign cti_o        = 3'b000;
  assign bte_o        = 2'b00;
  assign adr_o        = adr_q;
  assign sel_o        = sel_q;
  assign wbm_busy_o   = busy_q;
  assign err_o        = err_q;
  assign z_ack_o      = ack_q[0];
  assign blend_ack_o  = ack_q[1];
  assign tex_ack_o    = ack_q[2];
  assign z_data_o     = data_q[0];
  assign blend_data_o = data_q[1];
  assign tex_data_o   = data_q[2];
endmodule

// File: tb/tb_gfx256_wbm_read.sv
// Directed bench for gfx256_wbm_read with TIMEOUT=4; hand-computed addresses and data.
module tb_gfx256_wbm_read;
  logic               clk = 1'b0;
  logic               rst;
  logic [2:0]         req;
  logic [31:0]        addr [3];
  logic [31:0]        sel  [3];
  logic [2:0][255:0]  dout;
  logic [2:0]         ack_v;
  logic               busy, err, cyc, stb, we;
  logic [2:0]         cti;
  logic [1:0]         bte;
  logic [31:0]        adr, bsel;
  logic [255:0]       dat_i;
  logic               ack_i, err_i;
  logic [255:0]       exp_d [3];
  int                 n_tot = 0;
  int                 n_pass = 0;

  localparam logic [255:0] PAT_A = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] PAT_B = {8{32'h1234_5678}};
  localparam logic [255:0] PAT_C = {4{64'h0F0F_0000_FFFF_A5A5}};
  localparam logic [255:0] PAT_D = {16{16'hC3C3}};
  localparam logic [255:0] PAT_E = {32{8'h7E}};

  always #5 clk = ~clk;

  gfx256_wbm_read #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .z_request_i(req[0]), .z_addr_i(addr[0]), .z_sel_i(sel[0]),
    .z_data_o(dout[0]), .z_ack_o(ack_v[0]),
    .blend_request_i(req[1]), .blend_addr_i(addr[1]), .blend_sel_i(sel[1]),
    .blend_data_o(dout[1]), .blend_ack_o(ack_v[1]),
    .tex_request_i(req[2]), .tex_addr_i(addr[2]), .tex_sel_i(sel[2]),
    .tex_data_o(dout[2]), .tex_ack_o(ack_v[2]),
    .wbm_busy_o(busy), .err_o(err), .cyc_o(cyc), .stb_o(stb), .we_o(we),
    .cti_o(cti), .bte_o(bte), .adr_o(adr), .sel_o(bsel),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle where the client's request is already driven.
  // kind: 0 ack, 1 err, 2 timeout, 3 ack+err together.
  task automatic do_read(input int w, input logic [31:0] eadr, input int nwait,
                         input int kind, input logic [255:0] d, input logic [2:0] raise);
    step();
    chk("cyc_up", cyc, 1'b1);
    chk("stb_up", stb, 1'b1);
    chk("adr", adr, eadr);
    chk("sel", bsel, sel[w]);
    chk("busy_bus", busy, 1'b1);
    if (kind == 2) begin
      for (int i = 1; i < 4; i++) begin
        step();
        chk("cyc_hold_to", cyc, 1'b1);
      end
    end else begin
      repeat (nwait) begin
        step();
        chk("cyc_hold", cyc, 1'b1);
      end
      ack_i = (kind == 0 || kind == 3);
      err_i = (kind == 1 || kind == 3);
      dat_i = d;
    end
    step();
    ack_i = 1'b0;
    err_i = 1'b0;
    dat_i = '0;
    exp_d[w] = (kind == 0 || kind == 3) ? d : '0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ack_done%0d", i), ack_v[i], logic'(i == w));
      chk($sformatf("data%0d", i), dout[i], exp_d[i]);
    end
    chk("err_done", err, logic'(kind == 1 || kind == 2));
    chk("cyc_done", cyc, 1'b0);
    chk("busy_done", busy, 1'b1);
    req[w] = 1'b0;
    req = req | raise;
    step();
    chk("ack_clr", ack_v, 3'b000);
    chk("busy_idle", busy, 1'b0);
    chk("err_clr", err, 1'b0);
    chk("cyc_idle", cyc, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; sel[i] = '0; exp_d[i] = '0;
    end
    dat_i = '0; ack_i = 1'b0; err_i = 1'b0;
    repeat (3) step();
    chk("rst_cyc", cyc, 1'b0);
    chk("rst_stb", stb, 1'b0);
    chk("rst_adr", adr, 32'h0);
    chk("rst_sel", bsel, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ack", ack_v, 3'b000);
    chk("rst_data", dout, '0);
    chk("const_we", we, 1'b0);
    chk("const_cti", cti, 3'b000);
    chk("const_bte", bte, 2'b00);
    rst = 1'b0;
    step();

    // single z read, ack on 2nd BUS cycle
    addr[0] = 32'h0000_1234; sel[0] = 32'hFFFF_FFFF; req[0] = 1'b1;
    do_read(0, 32'h0000_1220, 1, 0, PAT_A, 3'b000);

    // all three at once: z, blend, tex in turn
    addr[0] = 32'h0000_0100; sel[0] = 32'h0000_FFFF;
    addr[1] = 32'h0000_205F; sel[1] = 32'hFFFF_0000;
    addr[2] = 32'hFFFF_FFE7; sel[2] = 32'h8000_0001;
    req = 3'b111;
    do_read(0, 32'h0000_0100, 0, 0, PAT_B, 3'b000);
    do_read(1, 32'h0000_2040, 1, 0, PAT_C, 3'b000);
    do_read(2, 32'hFFFF_FFE0, 2, 0, PAT_D, 3'b000);

    // blend bus error on 1st BUS cycle clears blend data
    addr[1] = 32'h0000_0040; sel[1] = 32'h0000_00FF; req[1] = 1'b1;
    do_read(1, 32'h0000_0040, 0, 1, PAT_E, 3'b000);

    // tex timeout after 4 bus cycles
    addr[2] = 32'h0000_0FFF; sel[2] = 32'h0F0F_0F0F; req[2] = 1'b1;
    do_read(2, 32'h0000_0FE0, 0, 2, PAT_E, 3'b000);

    // ack and err together: ack wins
    addr[2] = 32'h0000_0020; req[2] = 1'b1;
    do_read(2, 32'h0000_0020, 1, 3, PAT_E, 3'b000);

    // z raised during blend DONE: not granted in DONE, granted next IDLE
    addr[1] = 32'h0000_3000; sel[1] = 32'h0000_0F00; req[1] = 1'b1;
    addr[0] = 32'h0000_4444; sel[0] = 32'h1111_1111;
    do_read(1, 32'h0000_3000, 0, 0, PAT_A, 3'b001);
    chk("raised_pending", req[0] & ~cyc, 1'b1);
    do_read(0, 32'h0000_4440, 0, 0, PAT_C, 3'b000);

    // async reset mid-BUS
    addr[0] = 32'h0000_5000; sel[0] = 32'hFFFF_FFFF; req[0] = 1'b1;
    step();
    chk("pre_rst_cyc", cyc, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_cyc", cyc, 1'b0);
    chk("arst_stb", stb, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ack", ack_v, 3'b000);
    req[0] = 1'b0;
    step();
    chk("arst_noack", ack_v, 3'b000);
    chk("arst_data", dout, '0);
    for (int i = 0; i < 3; i++) exp_d[i] = '0;
    rst = 1'b0;
    step();
    req[0] = 1'b1;
    do_read(0, 32'h0000_5000, 1, 0, PAT_D, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/gfx256_wbm_read.md
# gfx256_wbm_read

Wishbone read master for the 256-bit graphics memory port. It serves the pipeline's read clients (z-buffer reads from clipping, blender destination reads, texture reads from fragment), which use a request/ack handshake. Pending requests are arbitrated at fixed priority. The block issues one single-beat 256-bit classic Wishbone read per grant, returns the line to the winner with a one-cycle ack, and reports `wbm_busy_o` so clients can hold off raising new requests.

## Interface
- `TIMEOUT`, 255: maximum bus-wait cycles before a cycle is aborted; valid range 1..255.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; asynchronous and active-high.
- `z_request_i` in 1: z-buffer read request; held high until `z_ack_o`.
- `z_addr_i` in 32: z read byte address.
- `z_sel_i` in 32: z byte select.
- `z_data_o` out 256: z read data.
- `z_ack_o` out 1: z done pulse.
- `blend_request_i`, `blend_addr_i`, `blend_sel_i`, `blend_data_o`, `blend_ack_o`: blender client, same widths and rules as z.
- `tex_request_i`, `tex_addr_i`, `tex_sel_i`, `tex_data_o`, `tex_ack_o`: texture client, same widths and rules as z.
- `wbm_busy_o` out 1: high whenever state is not IDLE.
- `err_o` out 1: one-cycle pulse, coincident with the client ack, when the read ended by `err_i` or timeout.
- `cyc_o`, `stb_o` out 1: Wishbone cycle and strobe.
- `we_o` out 1: constant 0.
- `cti_o` out 3: constant 3'b000, classic cycle.
- `bte_o` out 2: constant 2'b00.
- `adr_o` out 32: bus address.
- `sel_o` out 32: bus byte select.
- `dat_i` in 256: bus read data.
- `ack_i` in 1: bus acknowledge.
- `err_i` in 1: bus error.

## Operation
- **States:** IDLE, BUS, DONE.
- **IDLE:**
  - If any request is high, latch the winner, its address and its select.
  - Priority is fixed: z > blend > tex.
  - Next state is BUS, with `cyc_o`/`stb_o` = 1 from the next cycle.
  - `adr_o` = {addr[31:5], 5'b0}, aligned to 32 bytes; `sel_o` = client sel.
- **BUS:**
  - `cyc_o`, `stb_o`, `adr_o` and `sel_o` are held stable.
  - A wait counter increments each cycle in BUS.
  - On `ack_i`: latch `dat_i` into the winner's data register; drop `cyc_o`/`stb_o`; go to DONE.
  - On `err_i`, or when the counter reaches `TIMEOUT` without `ack_i`: latch all-zero data, flag error, go to DONE.
  - If `ack_i` and `err_i` arrive in the same cycle, `ack_i` wins and there is no error.
- **DONE:**
  - The winner's `*_ack_o` = 1 for exactly this cycle.
  - `err_o` = 1 if the error flag is set.
  - Requests are ignored in DONE, because the acked client drops its request at this edge.
  - Next state is IDLE.
- **Client data:**
  - Each `*_data_o` holds its last returned value until that client's next completion.
  - Non-winning clients' data is unchanged.
- **Requests raised while not IDLE** are tolerated. They stay pending and are evaluated on the next IDLE cycle; none are lost.
- **Request withdrawn while pending:** a client may not withdraw a request before its ack. If it does while in BUS, the cycle still completes and the ack is still pulsed.
- **Reset values:** all outputs 0 (`cyc_o`, `stb_o`, `adr_o`, `sel_o`, all data, all acks, `err_o`, `wbm_busy_o`); state IDLE; counter 0.
- **Async reset during BUS:** `cyc_o`/`stb_o` drop immediately; no client ack is issued. Clients must reissue after reset.

## Timing
- **Request latency:**
  - Request sampled in IDLE at cycle 0.
  - `cyc_o`/`stb_o` high at cycle 1.
  - `ack_i` seen at cycle k ≥ 1.
  - Client ack and valid data at cycle k+1.
  - IDLE again at cycle k+2.
  - Minimum request-to-ack is 2 cycles; back-to-back grant spacing is at least 3 cycles.
- **Bus outputs** (`cyc_o`, `stb_o`, `adr_o`, `sel_o`) are registered and change only on IDLE→BUS and BUS→DONE.
- `*_data_o` is valid from the ack cycle onward; the data register updates at the same edge that raises the ack.
- `wbm_busy_o` is high from cycle 1 through the DONE cycle inclusive and is registered.
- **Timeout:** the counter is cleared on entering BUS. Abort occurs on the cycle the counter equals `TIMEOUT`, i.e. `TIMEOUT` cycles after `cyc_o` rises with no `ack_i`.
- **Starvation:** tex can be starved by continuous z/blend traffic. This is accepted by design.

## Test plan
- **Single z read:**
  - Stimulus: `z_request_i`=1, `z_addr_i`=0x0000_1234, `z_sel_i`=0xFFFF_FFFF; `ack_i` on the 2nd BUS cycle with `dat_i`=pattern A.
  - Required: `adr_o`=0x0000_1220; `sel_o`=0xFFFF_FFFF; `z_ack_o` one cycle; `z_data_o`=A; `err_o`=0; back to IDLE.
- **Simultaneous z, blend, tex requests:**
  - Required: grants in order z, blend, tex.
  - Each ack is exactly one cycle; other clients' data is unchanged.
  - Grants are at least 3 cycles apart.
- **Bus error:**
  - Stimulus: `err_i`=1 on the 1st BUS cycle for a blend read.
  - Required: `blend_ack_o`=1 and `err_o`=1 in the same cycle; `blend_data_o`=0.
- **Timeout:**
  - Stimulus: `TIMEOUT`=4; no `ack_i` on a tex read.
  - Required: `cyc_o` high for exactly 4 cycles, then `tex_ack_o`=1 and `err_o`=1.
- **Async reset mid-BUS:**
  - Stimulus: assert `rst_i` while `cyc_o`=1.
  - Required: `cyc_o`, `stb_o` and `wbm_busy_o` go to 0 without waiting for a clock edge; no ack; after release, a new z request completes normally.
- **Request raised during DONE of another client:**
  - Required: the new request is not granted in the DONE cycle, is granted on the following IDLE cycle, and is not lost.
